// File: rtl/sysbus_mem_responder.sv
// Memory-side responder for the line-granular system bus: one 128-bit read or masked write at a time,
// fixed-latency response, invalidate snoop on every committed write. Optional counters: SYSBUS_MEM_STATS_EN.
module sysbus_mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [31:0] SIZE_BYTES = 32'h0004_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wdata,
    input  logic [15:0]  req_wmask,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_rdata,
    output logic         resp_error,
    output logic         inv_valid,
`ifdef SYSBUS_MEM_STATS_EN
    output logic [31:0]  stat_reads,
    output logic [31:0]  stat_writes,
    output logic [31:0]  stat_errors,
`endif
    output logic [31:0]  inv_addr
);

    localparam int unsigned LINES    = SIZE_BYTES / 16;
    localparam int unsigned IDX_W    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]       cnt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [127:0]     wdata_q;
    logic [15:0]      wmask_q;
    logic             accept;
    logic             commit;
    logic             in_range;
    logic [32:0]      addr_ext;
    logic [IDX_W-1:0] line_idx;

    logic [127:0] mem [LINES];

    // Ready is held low for the whole time reset is asserted, not only after the first edge.
    assign req_ready = (state == S_IDLE) && rst;
    assign accept    = req_valid && req_ready;
    assign commit    = (state == S_WAIT) && (cnt == 4'd0);

    // 33-bit compare so a window ending at 2^32 does not wrap.
    assign addr_ext = {1'b0, addr_q};
    assign in_range = (addr_ext >= {1'b0, BASE_ADDR}) &&
                      (addr_ext < ({1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES}));
    assign line_idx = IDX_W'((addr_q - BASE_ADDR) >> 4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (req_valid) state_next = S_WAIT;
            S_WAIT: if (cnt == 4'd0) state_next = S_RESP;
            S_RESP: if (resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 128'd0;
            wmask_q    <= 16'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 128'd0;
            resp_error <= 1'b0;
            inv_valid  <= 1'b0;
            inv_addr   <= 32'd0;
        end else begin
            inv_valid <= 1'b0;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wmask_q <= req_wmask;
                cnt     <= CNT_INIT;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            if (commit) begin
                resp_valid <= 1'b1;
                if (in_range) begin
                    resp_error <= 1'b0;
                    resp_rdata <= we_q ? 128'd0 : mem[line_idx];
                    if (we_q) begin
                        inv_valid <= 1'b1;
                        inv_addr  <= {addr_q[31:4], 4'h0};
                    end
                end else begin
                    resp_error <= 1'b1;
                    resp_rdata <= 128'd0;
                end
            end else if ((state == S_RESP) && resp_ready) begin
                resp_valid <= 1'b0;
                resp_rdata <= 128'd0;
                resp_error <= 1'b0;
            end
        end
    end

    // Backing store is not reset; only committed writes touch it.
    always_ff @(posedge clk) begin
        if (commit && in_range && we_q) begin
            for (int i = 0; i < 16; i++) begin
                if (wmask_q[i]) begin
                    mem[line_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

`ifdef SYSBUS_MEM_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_reads  <= 32'd0;
            stat_writes <= 32'd0;
            stat_errors <= 32'd0;
        end else if (commit) begin
            if (!in_range) begin
                if (stat_errors != 32'hFFFF_FFFF) stat_errors <= stat_errors + 32'd1;
            end else if (we_q) begin
                if (stat_writes != 32'hFFFF_FFFF) stat_writes <= stat_writes + 32'd1;
            end else begin
                if (stat_reads != 32'hFFFF_FFFF) stat_reads <= stat_reads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: transaction-level memory model with a per-cycle output compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sysbus_mem_responder;

    localparam int          LAT  = 2;
    localparam longint      BASE = 64'h8000_0000;
    localparam longint      SIZE = 64'h0004_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [31:0]  req_addr = 32'd0;
    logic [127:0] req_wdata = 128'd0;
    logic [15:0]  req_wmask = 16'd0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [127:0] resp_rdata;
    logic         resp_error;
    logic         inv_valid;
    logic [31:0]  inv_addr;
`ifdef SYSBUS_MEM_STATS_EN
    logic [31:0]  stat_reads;
    logic [31:0]  stat_writes;
    logic [31:0]  stat_errors;
`endif

    sysbus_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .inv_valid  (inv_valid),
`ifdef SYSBUS_MEM_STATS_EN
        .stat_reads (stat_reads),
        .stat_writes(stat_writes),
        .stat_errors(stat_errors),
`endif
        .inv_addr   (inv_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding request, aged in edges since acceptance.
    bit           outstanding = 1'b0;
    int           age = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           accepts = 0;
    int           handoffs = 0;
    logic         m_we;
    logic [31:0]  m_addr;
    logic [127:0] m_wdata;
    logic [15:0]  m_wmask;
    logic [127:0] mmem [int];
    logic [128:0] exp_q [$];
    bit           cur_inv = 1'b0;
    logic [31:0]  cur_inv_addr = 32'd0;
    logic [127:0] last_rdata = 128'd0;
    logic         last_err = 1'b0;

    task automatic model_commit();
        longint a;
        int idx;
        logic [127:0] l;
        a = longint'(m_addr);
        if (a >= BASE && a < BASE + SIZE) begin
            idx = int'((a - BASE) / 16);
            if (m_we) begin
                l = mmem.exists(idx) ? mmem[idx] : 128'd0;
                for (int b = 0; b < 16; b++)
                    if (m_wmask[b]) l[8*b +: 8] = m_wdata[8*b +: 8];
                mmem[idx] = l;
                exp_q.push_back({1'b0, 128'd0});
                cur_inv = 1'b1;
                cur_inv_addr = m_addr & 32'hFFFF_FFF0;
            end else begin
                exp_q.push_back({1'b0, mmem[idx]});
            end
        end else begin
            exp_q.push_back({1'b1, 128'd0});
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding = 1'b0;
            age = 0;
            cur_inv = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            if (outstanding) begin
                if (age >= LAT && resp_ready) begin
                    last_rdata = resp_rdata;
                    last_err = resp_error;
                    outstanding = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    handoffs++;
                end else begin
                    age++;
                    if (age == LAT) model_commit();
                end
            end else if (req_valid) begin
                m_we = req_we;
                m_addr = req_addr;
                m_wdata = req_wdata;
                m_wmask = req_wmask;
                outstanding = 1'b1;
                age = 0;
                cur_inv = 1'b0;
                acc_cyc = cyc;
                accepts++;
            end
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    bit   exp_rv;
    bit   exp_iv;
    bit   prev_rv = 1'b0;
    int   inv_cnt = 0;
    int   lat_seen = 0;
    logic [31:0] last_inv_addr = 32'd0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_ready", {127'd0, req_ready}, 128'd0);
            chk("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
            chk("rst_resp_rdata", resp_rdata, 128'd0);
            chk("rst_resp_error", {127'd0, resp_error}, 128'd0);
            chk("rst_inv_valid", {127'd0, inv_valid}, 128'd0);
            chk("rst_inv_addr", {96'd0, inv_addr}, 128'd0);
        end else begin
            exp_rv = outstanding && (age >= LAT);
            exp_iv = outstanding && (age == LAT) && cur_inv;
            chk("req_ready", {127'd0, req_ready}, {127'd0, !outstanding});
            chk("resp_valid", {127'd0, resp_valid}, {127'd0, exp_rv});
            if (exp_rv && exp_q.size() > 0) begin
                chk("resp_rdata", resp_rdata, exp_q[0][127:0]);
                chk("resp_error", {127'd0, resp_error}, {127'd0, exp_q[0][128]});
            end
            chk("inv_valid", {127'd0, inv_valid}, {127'd0, exp_iv});
            if (exp_iv) chk("inv_addr", {96'd0, inv_addr}, {96'd0, cur_inv_addr});
        end
        if (inv_valid) begin
            inv_cnt++;
            last_inv_addr = inv_addr;
        end
        if (resp_valid && !prev_rv) lat_seen = cyc - acc_cyc;
        prev_rv = resp_valid;
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                          input logic [15:0] wm, input int stall);
        int n0;
        int h0;
        int t;
        n0 = accepts;
        h0 = handoffs;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = wd;
        req_wmask = wm;
        resp_ready = 1'b0;
        t = 0;
        while (accepts == n0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (accepts == n0) begin
            req_valid = 1'b0;
            chk("accept_timeout", 128'd1, 128'd0);
            return;
        end
        t = 0;
        while (handoffs == h0 && t < 200) begin
            resp_ready = (t >= stall) ? ($urandom_range(0, 3) != 0) : 1'b0;
            req_valid = 1'(($urandom_range(0, 1)));
            req_we = 1'(($urandom_range(0, 1)));
            req_addr = $urandom();
            req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            req_wmask = 16'($urandom());
            @(negedge clk);
            t++;
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        if (handoffs == h0) chk("resp_timeout", 128'd1, 128'd0);
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, "_req_ready"}, {127'd0, req_ready}, 128'd0);
        chk({tag, "_resp_valid"}, {127'd0, resp_valid}, 128'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 128'd0);
        chk({tag, "_inv_valid"}, {127'd0, inv_valid}, 128'd0);
        chk({tag, "_inv_addr"}, {96'd0, inv_addr}, 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [127:0] pool_data [9];

    function automatic logic [31:0] pool_addr(input int p);
        return (p == 8) ? 32'h8003_FFF0 : (32'h8000_0000 + 32'(p) * 32'd16);
    endfunction

    initial begin
        int n0;
        int t;
        int inv0;
        int p;
        int k;
        logic [127:0] d;
        logic [31:0] a;
        logic [31:0] oor [4];
        oor[0] = 32'h8004_0000;
        oor[1] = 32'h7FFF_FFF0;
        oor[2] = 32'hFFFF_FFF0;
        oor[3] = 32'h0000_0000;

        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            pool_data[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            do_req(1'b1, pool_addr(i), pool_data[i], 16'hFFFF, 0);
        end

        // Full write of 0x11 then read back with low address bits set.
        do_req(1'b1, 32'h8000_0010, {16{8'h11}}, 16'hFFFF, 0);
        do_req(1'b0, 32'h8000_001C, 128'd0, 16'd0, 0);
        chk("full_rd_data", last_rdata, {16{8'h11}});
        chk("full_rd_err", {127'd0, last_err}, 128'd0);
        chk("latency", 128'(lat_seen), 128'd2);

        inv0 = inv_cnt;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        d[7:0] = 8'hAA;
        do_req(1'b1, 32'h8000_0010, d, 16'h0001, 0);
        chk("partial_inv_cnt", 128'(inv_cnt - inv0), 128'd1);
        chk("partial_inv_addr", {96'd0, last_inv_addr}, {96'd0, 32'h8000_0010});
        do_req(1'b0, 32'h8000_0010, 128'd0, 16'd0, 0);
        chk("partial_rd_data", last_rdata, {{15{8'h11}}, 8'hAA});

        inv0 = inv_cnt;
        do_req(1'b0, 32'h8004_0000, 128'd0, 16'd0, 0);
        chk("oor_hi_err", {127'd0, last_err}, 128'd1);
        chk("oor_hi_data", last_rdata, 128'd0);
        do_req(1'b0, 32'h7FFF_FFF0, 128'd0, 16'd0, 0);
        chk("oor_lo_err", {127'd0, last_err}, 128'd1);
        chk("oor_lo_data", last_rdata, 128'd0);
        do_req(1'b1, 32'h8004_0010, {16{8'h55}}, 16'hFFFF, 0);
        chk("oor_wr_err", {127'd0, last_err}, 128'd1);
        chk("oor_inv_cnt", 128'(inv_cnt - inv0), 128'd0);
        do_req(1'b0, 32'h8003_FFF0, 128'd0, 16'd0, 0);
        chk("last_line_err", {127'd0, last_err}, 128'd0);
        chk("last_line_data", last_rdata, pool_data[8]);

        // Long backpressure with junk requests offered while busy.
        do_req(1'b0, 32'h8000_0010, 128'd0, 16'd0, LAT + 5);
        chk("stall_rd_data", last_rdata, {{15{8'h11}}, 8'hAA});

        inv0 = inv_cnt;
        do_req(1'b1, 32'h8000_0010, 128'hDEAD, 16'h0000, 0);
        chk("zmask_inv_cnt", 128'(inv_cnt - inv0), 128'd1);
        do_req(1'b0, 32'h8000_0010, 128'd0, 16'd0, 0);
        chk("zmask_rd_data", last_rdata, {{15{8'h11}}, 8'hAA});

        // Reset while a write to line 2 is still waiting to commit.
        inv0 = inv_cnt;
        n0 = accepts;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h8000_0020;
        req_wdata = ~pool_data[2];
        req_wmask = 16'hFFFF;
        t = 0;
        while (accepts == n0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        req_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_now("midrst");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        chk("midrst_inv_cnt", 128'(inv_cnt - inv0), 128'd0);
        do_req(1'b0, 32'h8000_0020, 128'd0, 16'd0, 0);
        chk("midrst_rd_data", last_rdata, pool_data[2]);

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 9);
            if (k < 8) begin
                p = $urandom_range(0, 8);
                a = pool_addr(p) | 32'($urandom_range(0, 15));
            end else begin
                a = oor[$urandom_range(0, 3)] | 32'($urandom_range(0, 15));
            end
            case ($urandom_range(0, 3))
                0: d = {16{8'($urandom())}};
                default: d = {$urandom(), $urandom(), $urandom(), $urandom()};
            endcase
            do_req(1'($urandom_range(0, 1)), a, d,
                   ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom()),
                   $urandom_range(0, 3));
        end

`ifdef SYSBUS_MEM_STATS_EN
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        do_req(1'b0, pool_addr(0), 128'd0, 16'd0, 0);
        do_req(1'b0, pool_addr(3), 128'd0, 16'd0, 0);
        do_req(1'b0, pool_addr(5), 128'd0, 16'd0, 0);
        do_req(1'b1, pool_addr(4), 128'd7, 16'h00FF, 0);
        do_req(1'b1, pool_addr(6), 128'd9, 16'hFFFF, 0);
        do_req(1'b0, 32'h8004_0000, 128'd0, 16'd0, 0);
        chk("stat_reads", {96'd0, stat_reads}, 128'd3);
        chk("stat_writes", {96'd0, stat_writes}, 128'd2);
        chk("stat_errors", {96'd0, stat_errors}, 128'd1);
        @(negedge clk);
        force dut.stat_reads = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.stat_reads;
        do_req(1'b0, pool_addr(0), 128'd0, 16'd0, 0);
        chk("stat_reads_sat", {96'd0, stat_reads}, {96'd0, 32'hFFFF_FFFF});
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
